prod_row_reduce: RTL and testbench

PROD_ROW_REDUCE -- requirements
Module: prod_row_reduce

---
 rtl/prod_row_reduce.sv | 131 +++++++++++++
 tb/tb_prod_row_reduce.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/prod_row_reduce.sv
// Streams a 16x16 frame of unsigned 8-bit elements (row-major) and reports per-row sum/max
// one cycle after each row completes, plus the frame total and a completed-frame count.
module prod_row_reduce (
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        clr,
  output logic        out_valid,
  output logic [3:0]  out_row_idx,
  output logic [11:0] out_row_sum,
  output logic [7:0]  out_row_max,
  output logic        out_total_valid,
  output logic [15:0] out_total,
  output logic [7:0]  out_frame_cnt
);

  typedef enum logic {IDLE, ACC} state_t;

  function automatic logic [7:0] umax8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_col;
  logic [3:0]  r_row;
  logic [11:0] r_row_sum;
  logic [7:0]  r_row_max;
  logic [15:0] r_total;
  logic [7:0]  r_frame_cnt;

  logic        r_out_valid;
  logic [3:0]  r_out_row_idx;
  logic [11:0] r_out_row_sum;
  logic [7:0]  r_out_row_max;
  logic        r_out_total_valid;
  logic [15:0] r_out_total;

  logic        w_accept;
  logic        w_col_end;
  logic        w_last;
  logic [11:0] w_sum_nxt;
  logic [7:0]  w_max_nxt;
  logic [15:0] w_total_nxt;

  assign w_accept    = in_valid & ~clr;
  assign w_col_end   = (r_col == 4'd15);
  // Element 255 can only arrive once the frame is already in ACC
  assign w_last      = (r_state == ACC) && (r_row == 4'd15) && w_col_end;
  assign w_sum_nxt   = r_row_sum + {4'd0, in_data};
  assign w_max_nxt   = umax8(r_row_max, in_data);
  assign w_total_nxt = r_total + {8'd0, in_data};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = ACC;
      ACC: begin
        if (clr) w_state_nxt = IDLE;
        else if (w_accept && w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state           <= IDLE;
      r_col             <= '0;
      r_row             <= '0;
      r_row_sum         <= '0;
      r_row_max         <= '0;
      r_total           <= '0;
      r_frame_cnt       <= '0;
      r_out_valid       <= 1'b0;
      r_out_row_idx     <= '0;
      r_out_row_sum     <= '0;
      r_out_row_max     <= '0;
      r_out_total_valid <= 1'b0;
      r_out_total       <= '0;
    end else begin
      r_state           <= w_state_nxt;
      // Result fields read zero outside their one-cycle pulse
      r_out_valid       <= 1'b0;
      r_out_row_idx     <= '0;
      r_out_row_sum     <= '0;
      r_out_row_max     <= '0;
      r_out_total_valid <= 1'b0;
      r_out_total       <= '0;
      if (clr) begin
        r_col     <= '0;
        r_row     <= '0;
        r_row_sum <= '0;
        r_row_max <= '0;
        r_total   <= '0;
      end else if (w_accept) begin
        r_col <= r_col + 4'd1;
        if (w_col_end) begin
          r_row         <= r_row + 4'd1;
          r_row_sum     <= '0;
          r_row_max     <= '0;
          r_out_valid   <= 1'b1;
          r_out_row_idx <= r_row;
          r_out_row_sum <= w_sum_nxt;
          r_out_row_max <= w_max_nxt;
        end else begin
          r_row_sum <= w_sum_nxt;
          r_row_max <= w_max_nxt;
        end
        if (w_last) begin
          r_total           <= '0;
          r_frame_cnt       <= r_frame_cnt + 8'd1;
          r_out_total_valid <= 1'b1;
          r_out_total       <= w_total_nxt;
        end else begin
          r_total <= w_total_nxt;
        end
      end
    end
  end

  assign out_valid       = r_out_valid;
  assign out_row_idx     = r_out_row_idx;
  assign out_row_sum     = r_out_row_sum;
  assign out_row_max     = r_out_row_max;
  assign out_total_valid = r_out_total_valid;
  assign out_total       = r_out_total;
  assign out_frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_prod_row_reduce.sv
// Directed bench for prod_row_reduce: per-cycle comparison against a frame-array model,
// plus hand-computed row/frame results for each scenario.
module tb_prod_row_reduce;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        clr;
  logic        out_valid;
  logic [3:0]  out_row_idx;
  logic [11:0] out_row_sum;
  logic [7:0]  out_row_max;
  logic        out_total_valid;
  logic [15:0] out_total;
  logic [7:0]  out_frame_cnt;

  prod_row_reduce dut (
    .clk1(clk1), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .clr(clr),
    .out_valid(out_valid), .out_row_idx(out_row_idx), .out_row_sum(out_row_sum),
    .out_row_max(out_row_max), .out_total_valid(out_total_valid), .out_total(out_total),
    .out_frame_cnt(out_frame_cnt)
  );

  always #5 clk1 = ~clk1;

  int checks = 0;
  int failures = 0;

  // Model state: k = index of the next element in the current frame
  int          k;
  logic [7:0]  fr [256];
  logic [7:0]  fcnt;
  logic [24:0] e_row;
  logic [24:0] e_tot;

  logic [11:0] cap_sum [16];
  logic [7:0]  cap_max [16];
  logic [15:0] cap_total;
  int          npulse;
  int          ntot;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_caps();
    for (int r = 0; r < 16; r++) begin
      cap_sum[r] = '0;
      cap_max[r] = '0;
    end
    cap_total = '0;
    npulse = 0;
    ntot = 0;
  endtask

  // Called at a negedge: check outputs of the last posedge, apply inputs, predict next outputs
  task automatic cycle(input logic v, input logic [7:0] d, input logic c);
    int s;
    int t;
    int r;
    logic [7:0] m;
    logic [11:0] s12;
    logic [15:0] t16;
    logic [3:0] r4;
    chk("row_out", {7'd0, out_valid, out_row_idx, out_row_sum, out_row_max}, {7'd0, e_row});
    chk("tot_out", {7'd0, out_total_valid, out_total, out_frame_cnt}, {7'd0, e_tot});
    if (out_valid) begin
      cap_sum[out_row_idx] = out_row_sum;
      cap_max[out_row_idx] = out_row_max;
      npulse++;
    end
    if (out_total_valid) begin
      cap_total = out_total;
      ntot++;
    end
    in_valid = v;
    in_data  = d;
    clr      = c;
    e_row = '0;
    e_tot = {1'b0, 16'd0, fcnt};
    if (c) begin
      k = 0;
    end else if (v) begin
      fr[k] = d;
      if (k % 16 == 15) begin
        r = k / 16;
        s = 0;
        m = 8'd0;
        for (int j = 0; j < 16; j++) begin
          s += fr[r*16 + j];
          if (fr[r*16 + j] > m) m = fr[r*16 + j];
        end
        s12 = s[11:0];
        r4 = r[3:0];
        e_row = {1'b1, r4, s12, m};
      end
      if (k == 255) begin
        t = 0;
        for (int j = 0; j < 256; j++) t += fr[j];
        t16 = t[15:0];
        fcnt = fcnt + 8'd1;
        e_tot = {1'b1, t16, fcnt};
        k = 0;
      end else begin
        k++;
      end
    end
    @(negedge clk1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    clr = 1'b0;
    #1;
    chk("rst_async", {7'd0, out_valid, out_row_idx, out_row_sum, out_row_max,
                      out_total_valid, out_total, out_frame_cnt}, 32'd0);
    @(negedge clk1);
    @(negedge clk1);
    rst_n = 1'b1;
    k = 0;
    fcnt = '0;
    e_row = '0;
    e_tot = '0;
    clear_caps();
  endtask

  initial begin
    rst_n = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    clr = 1'b0;
    k = 0;
    fcnt = '0;
    e_row = '0;
    e_tot = '0;
    @(negedge clk1);

    // Idle after reset: all outputs zero
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1'b0, 8'd0, 1'b0);

    // Constant 225 frame
    for (int i = 0; i < 256; i++) cycle(1'b1, 8'd225, 1'b0);
    cycle(1'b0, 8'd0, 1'b0);
    chk("c225_npulse", npulse, 16);
    for (int r = 0; r < 16; r++) begin
      chk("c225_sum", cap_sum[r], 32'd3600);
      chk("c225_max", cap_max[r], 32'd225);
    end
    chk("c225_total", cap_total, 32'd57600);
    chk("c225_fcnt", out_frame_cnt, 32'd1);

    // Product pattern with random gaps
    do_reset();
    for (int i = 0; i < 256; i++) begin
      int gap;
      gap = $urandom_range(0, 5);
      for (int g = 0; g < gap; g++) cycle(1'b0, 8'd0, 1'b0);
      cycle(1'b1, 8'((i % 16) * (i / 16)), 1'b0);
    end
    cycle(1'b0, 8'd0, 1'b0);
    for (int r = 0; r < 16; r++) begin
      chk("prod_sum", cap_sum[r], 120 * r);
      chk("prod_max", cap_max[r], 15 * r);
    end
    chk("prod_total", cap_total, 32'd14400);

    // Abort after element 100 (clr with in_valid high), then a frame of ones; clr right after it
    do_reset();
    for (int i = 0; i <= 100; i++) cycle(1'b1, 8'd7, 1'b0);
    cycle(1'b1, 8'd99, 1'b1);
    chk("clr_nototal", ntot, 0);
    chk("clr_fcnt", out_frame_cnt, 32'd0);
    cycle(1'b0, 8'd0, 1'b1);
    clear_caps();
    for (int i = 0; i < 256; i++) cycle(1'b1, 8'd1, 1'b0);
    cycle(1'b0, 8'd0, 1'b1);
    cycle(1'b0, 8'd0, 1'b0);
    chk("ones_npulse", npulse, 16);
    for (int r = 0; r < 16; r++) chk("ones_sum", cap_sum[r], 32'd16);
    chk("ones_total", cap_total, 32'd256);
    chk("ones_fcnt", out_frame_cnt, 32'd1);

    // Reset after element 37, then a frame of twos
    do_reset();
    for (int i = 0; i <= 37; i++) cycle(1'b1, 8'd9, 1'b0);
    do_reset();
    for (int i = 0; i < 256; i++) cycle(1'b1, 8'd2, 1'b0);
    cycle(1'b0, 8'd0, 1'b0);
    for (int r = 0; r < 16; r++) chk("twos_sum", cap_sum[r], 32'd32);
    chk("twos_total", cap_total, 32'd512);
    chk("twos_fcnt", out_frame_cnt, 32'd1);

    // 300 back-to-back random frames: frame count wraps to 44
    do_reset();
    for (int f = 0; f < 300; f++)
      for (int i = 0; i < 256; i++) cycle(1'b1, 8'($urandom_range(0, 225)), 1'b0);
    cycle(1'b0, 8'd0, 1'b0);
    chk("rand_ntot", ntot, 300);
    chk("rand_fcnt", out_frame_cnt, 32'd44);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
